// File: rtl/opl3_i2s_tx.sv
// opl3_i2s_tx: captures OPL3 channels on sample_clk, mixes to saturated stereo,
// buffers in a small FIFO and serialises as Philips I2S.
module opl3_i2s_tx #(
  parameter int BCLK_HALF  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MIX_MODE   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          clr_i,
  input  logic                          sample_clk_i,
  input  logic [15:0]                   channel_a_i,
  input  logic [15:0]                   channel_b_i,
  input  logic [15:0]                   channel_c_i,
  input  logic [15:0]                   channel_d_i,
  output logic                          i2s_bclk_o,
  output logic                          i2s_lrclk_o,
  output logic                          i2s_sdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  output logic                          overflow_o,
  output logic [15:0]                   underrun_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q, state_d;
  logic [2:0]      sync_q, sync_d;
  logic [DW-1:0]   div_q, div_d;
  logic            bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic            und_q, und_d, ovf_q, ovf_d;
  logic [5:0]      slot_q, slot_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [31:0]     mem_d [FIFO_DEPTH];
  logic [31:0]     held_q, held_d;
  logic [15:0]     cnt_q, cnt_d, cnt_base;
  logic            run, push, tick, fall, wrap, empty, full;
  logic            pop_ok, push_ok, und_ev, ovf_ev;
  logic [AW:0]     level;
  logic [5:0]      ns;
  logic [3:0]      idx;
  logic [16:0]     sum_l, sum_r;
  function automatic logic [15:0] sat(input logic [16:0] s);
    return (s[16] ^ s[15]) ? {s[16], {15{~s[16]}}} : s[15:0];
  endfunction
  always_comb begin
    run      = state_q == RUN && enable_i;
    push     = sync_q[1] & ~sync_q[2];
    level    = wr_q - rd_q;
    empty    = level == '0;
    full     = level == (AW+1)'(FIFO_DEPTH);
    tick     = run && div_q == DW'(BCLK_HALF - 1);
    fall     = tick & bclk_q;
    wrap     = fall && slot_q == 6'd63;
    pop_ok   = wrap & ~empty;
    und_ev   = wrap & empty;
    push_ok  = run & push & (~full | pop_ok);
    ovf_ev   = run & push & full & ~pop_ok;
    ns       = slot_q + 6'd1;
    // 16-ns and 48-ns share the same low nibble, so one index serves both words
    idx      = 4'd0 - ns[3:0];
    sum_l    = MIX_MODE != 0 ? {channel_a_i[15], channel_a_i} + {channel_c_i[15], channel_c_i}
                             : {channel_a_i[15], channel_a_i};
    sum_r    = MIX_MODE != 0 ? {channel_b_i[15], channel_b_i} + {channel_d_i[15], channel_d_i}
                             : {channel_b_i[15], channel_b_i};
    state_d  = enable_i ? RUN : IDLE;
    sync_d   = {sync_q[1:0], sample_clk_i};
    div_d    = (!run || tick) ? '0 : div_q + DW'(1);
    bclk_d   = run & (bclk_q ^ tick);
    slot_d   = !run ? '0 : fall ? ns : slot_q;
    lrclk_d  = !run ? 1'b0 : fall ? ns[5] : lrclk_q;
    sdata_d  = !run ? 1'b0 : !fall ? sdata_q :
               (ns >= 6'd1 && ns <= 6'd16)  ? held_q[{1'b1, idx}] :
               (ns >= 6'd33 && ns <= 6'd48) ? held_q[{1'b0, idx}] : 1'b0;
    wr_d     = run ? wr_q + (AW+1)'(push_ok) : '0;
    rd_d     = run ? rd_q + (AW+1)'(pop_ok) : '0;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = {sat(sum_l), sat(sum_r)};
    held_d   = !run ? '0 : pop_ok ? mem_q[rd_q[AW-1:0]] : held_q;
    und_d    = (und_q & ~clr_i) | und_ev;
    ovf_d    = (ovf_q & ~clr_i) | ovf_ev;
    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = (und_ev && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      slot_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      mem_q   <= '{default: '0};
      held_q  <= '0;
      und_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      slot_q  <= slot_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
      held_q  <= held_d;
      und_q   <= und_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign i2s_bclk_o     = bclk_q;
  assign i2s_lrclk_o    = lrclk_q;
  assign i2s_sdata_o    = sdata_q;
  assign fifo_level_o   = level;
  assign underrun_o     = und_q;
  assign overflow_o     = ovf_q;
  assign underrun_cnt_o = cnt_q;
endmodule
